// File: rtl/bram_if_pkg.sv
//------------------------------------------------------------------------------
// Module  : bram_if_pkg
// Brief   : Shared BRAM row-interface widths, FSM state encoding, word select helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bram_if_pkg;

    localparam int BRAM_ADDR_W   = 13;
    localparam int BRAM_WORD_W   = 32;
    localparam int WORDS_PER_ROW = 16;
    localparam int ROW_W         = 9;
    localparam int ROW_BITS      = BRAM_WORD_W * WORDS_PER_ROW;
    localparam int WORD_IDX_W    = 4;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } wr_state_e;

    // Word 0 is the most significant 32 bits of the row.
    function automatic logic [BRAM_WORD_W-1:0] row_word(
        input logic [ROW_BITS-1:0]   row_data,
        input logic [WORD_IDX_W-1:0] idx
    );
        return row_data[ROW_BITS - 1 - BRAM_WORD_W * int'(idx) -: BRAM_WORD_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/wr_512b_to_bram.sv
//------------------------------------------------------------------------------
// Module  : wr_512b_to_bram
// Brief   : Writes one 512-bit row into BRAM as 16 sequential 32-bit handshaked
//           writes. Optional WR512_TIMEOUT_EN adds a per-phase ack timeout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wr_512b_to_bram
    import bram_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_trig,
    output logic                   o_done,
    input  logic [ROW_W-1:0]       i_wr_row_num,
    input  logic [ROW_BITS-1:0]    i_wr_data_512b,
    output logic [BRAM_ADDR_W-1:0] o_wr_to_bram_addr,
    output logic [BRAM_WORD_W-1:0] o_wr_to_bram_data,
    output logic                   o_wr_to_bram_trig,
    input  logic                   i_wr_to_bram_done,
    output logic                   o_err
);

    wr_state_e             state, state_nxt;
    logic [WORD_IDX_W-1:0] word_idx, word_idx_nxt;
    logic                  bram_trig, bram_trig_nxt;
    logic                  done_reg, done_reg_nxt;
    logic [ROW_W-1:0]      row_snap;
    logic [ROW_BITS-1:0]   data_snap;
    logic                  tmo_fire;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            bram_trig <= 1'b0;
            done_reg  <= 1'b0;
            row_snap  <= '0;
            data_snap <= '0;
        end else begin
            state     <= state_nxt;
            word_idx  <= word_idx_nxt;
            bram_trig <= bram_trig_nxt;
            done_reg  <= done_reg_nxt;
            if (state == ST_LATCH) begin
                row_snap  <= i_wr_row_num;
                data_snap <= i_wr_data_512b;
            end
        end
    end

    // Trig is set on the transition into REQ so each word costs 4 cycles with a prompt responder.
    always_comb begin
        state_nxt     = state;
        word_idx_nxt  = word_idx;
        bram_trig_nxt = bram_trig;
        done_reg_nxt  = done_reg;
        case (state)
            ST_IDLE: begin
                done_reg_nxt  = 1'b0;
                bram_trig_nxt = 1'b0;
                if (i_trig) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                word_idx_nxt  = '0;
                bram_trig_nxt = 1'b1;
                state_nxt     = ST_REQ;
            end
            ST_REQ: begin
                if (i_wr_to_bram_done) begin
                    bram_trig_nxt = 1'b0;
                    state_nxt     = ST_RELEASE;
                end else if (tmo_fire) begin
                    bram_trig_nxt = 1'b0;
                    state_nxt     = ST_DONE;
                end
            end
            ST_RELEASE: begin
                bram_trig_nxt = 1'b0;
                if (tmo_fire) begin
                    state_nxt = ST_DONE;
                end else if (!i_wr_to_bram_done) begin
                    if (word_idx == LAST_WORD) begin
                        state_nxt = ST_DONE;
                    end else begin
                        word_idx_nxt  = word_idx + 1'b1;
                        bram_trig_nxt = 1'b1;
                        state_nxt     = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                if (i_trig) begin
                    done_reg_nxt = 1'b1;
                end else begin
                    done_reg_nxt = 1'b0;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                bram_trig_nxt = 1'b0;
                done_reg_nxt  = 1'b0;
                state_nxt     = ST_IDLE;
            end
        endcase
    end

`ifdef WR512_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_reg;
    logic       waiting;

    assign waiting  = ((state == ST_REQ) && !i_wr_to_bram_done) ||
                      ((state == ST_RELEASE) && i_wr_to_bram_done);
    assign tmo_fire = waiting && (tmo_cnt == 8'(TIMEOUT_CYC - 1));

    // Counter restarts on every phase change so each REQ and RELEASE gets a full budget.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmo_cnt <= '0;
            err_reg <= 1'b0;
        end else begin
            if (waiting && (state_nxt == state)) tmo_cnt <= tmo_cnt + 8'd1;
            else                                 tmo_cnt <= '0;
            if (state == ST_LATCH)   err_reg <= 1'b0;
            else if (tmo_fire)       err_reg <= 1'b1;
        end
    end

    assign o_err = err_reg;
`else
    assign tmo_fire = 1'b0;
    // Evaluates to constant 0; referencing the parameter keeps both builds lint-identical.
    assign o_err    = (TIMEOUT_CYC < 0);
`endif

    assign o_wr_to_bram_addr = {row_snap, word_idx};
    assign o_wr_to_bram_data = row_word(data_snap, word_idx);
    assign o_wr_to_bram_trig = bram_trig;
    assign o_done            = done_reg & i_trig;

endmodule

`default_nettype wire

// File: tb/tb_wr_512b_to_bram.sv
//------------------------------------------------------------------------------
// Module  : tb_wr_512b_to_bram
// Brief   : Directed self-checking bench for wr_512b_to_bram with a BRAM
//           controller responder model (configurable ack hold / silence).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wr_512b_to_bram;

    logic         clk;
    logic         rstn;
    logic         trig;
    logic         done;
    logic [8:0]   row;
    logic [511:0] data;
    logic [12:0]  addr;
    logic [31:0]  wdata;
    logic         btrig;
    logic         bdone;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        prev_trig = 1'b0;
    logic [12:0] cur_a = '0;
    logic [31:0] cur_d = '0;
    int          stab_err = 0;
    int          extra_hold = 0;
    int          hold_left = 0;
    int          silent_word = -1;

`ifdef WR512_TIMEOUT_EN
    localparam int c_TB_TIMEOUT_CYC = 20;
`else
    localparam int c_TB_TIMEOUT_CYC = 255;
`endif

    wr_512b_to_bram #(.TIMEOUT_CYC(c_TB_TIMEOUT_CYC)) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_trig            (trig),
        .o_done            (done),
        .i_wr_row_num      (row),
        .i_wr_data_512b    (data),
        .o_wr_to_bram_addr (addr),
        .o_wr_to_bram_data (wdata),
        .o_wr_to_bram_trig (btrig),
        .i_wr_to_bram_done (bdone),
        .o_err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each write request on its rising edge; flag any addr/data movement while trig is high.
    always @(negedge clk) begin
        if (btrig && !prev_trig) begin
            log_addr.push_back(addr);
            log_data.push_back(wdata);
            cur_a = addr;
            cur_d = wdata;
        end else if (btrig && ((addr !== cur_a) || (wdata !== cur_d))) begin
            stab_err++;
        end
        prev_trig = btrig;
    end

    // Controller model: ack one cycle after trig seen, release one cycle (+extra_hold) after trig drops.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            bdone     = 1'b0;
            hold_left = 0;
        end else if (prev_trig && !bdone) begin
            if (int'(addr[3:0]) != silent_word) begin
                bdone     = 1'b1;
                hold_left = extra_hold;
            end
        end else if (!prev_trig && bdone) begin
            if (hold_left > 0) hold_left--;
            else               bdone = 1'b0;
        end
    end

    function automatic logic [511:0] make_row(input logic [31:0] base, input logic [31:0] step);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[511 - 32*k -: 32] = base + 32'(k) * step;
        return v;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        stab_err = 0;
    endtask

    // Raise trig and count edges until o_done; optional input scrambling after the LATCH cycle.
    task automatic run_row(input logic [8:0] r, input logic [511:0] d, input bit scramble,
                           input int limit, output int cyc, output bit ok);
        row  = r;
        data = d;
        trig = 1'b1;
        cyc  = 0;
        ok   = 1'b0;
        while (cyc < limit && !ok) begin
            @(posedge clk); #1;
            cyc++;
            if (done) ok = 1'b1;
            else if (scramble && cyc >= 2) begin
                row = 9'($urandom);
                for (int k = 0; k < 16; k++) data[32*k +: 32] = $urandom;
            end
        end
    endtask

    task automatic finish_row();
        trig = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rstn = 1'b0; trig = 1'b0; row = '0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (btrig !== 1'b0)  begin n_errors++; $display("FAIL reset_trig: got %b want 0", btrig); end
        n_checks++; if (addr !== 13'h0)  begin n_errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_checks++; if (wdata !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", wdata); end
        n_checks++; if (done !== 1'b0)   begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_row();
        int cyc; bit ok;
        clear_log();
        run_row(9'd5, make_row(32'hA000_0000, 32'h1), 1'b0, 200, cyc, ok);
        n_checks++; if (!ok || cyc != 67) begin n_errors++; $display("FAIL basic_latency: got ok=%0b cyc=%0d want cyc=67", ok, cyc); end
        n_checks++; if (log_addr.size() != 16) begin n_errors++; $display("FAIL basic_count: got %0d want 16", log_addr.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < log_addr.size()) begin
                n_checks++;
                if (log_addr[k] !== 13'h050 + 13'(k)) begin n_errors++; $display("FAIL basic_addr[%0d]: got %h want %h", k, log_addr[k], 13'h050 + 13'(k)); end
                n_checks++;
                if (log_data[k] !== 32'hA000_0000 + 32'(k)) begin n_errors++; $display("FAIL basic_data[%0d]: got %h want %h", k, log_data[k], 32'hA000_0000 + 32'(k)); end
            end
        end
        n_checks++; if (stab_err != 0) begin n_errors++; $display("FAIL basic_stable: got %0d changes want 0", stab_err); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b want 0", err); end
        // Holding trig high must neither re-trigger nor drop o_done.
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL hold_done: got %b want 1", done); end
        n_checks++; if (log_addr.size() != 16 || btrig !== 1'b0) begin n_errors++; $display("FAIL hold_retrig: got count=%0d trig=%b want 16/0", log_addr.size(), btrig); end
        trig = 1'b0;
        #1;
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL done_comb_drop: got %b want 0", done); end
        finish_row();
    endtask

    task automatic test_snapshot();
        int cyc; bit ok;
        clear_log();
        run_row(9'd5, make_row(32'hB000_0000, 32'h11), 1'b1, 200, cyc, ok);
        n_checks++; if (!ok || log_addr.size() != 16) begin n_errors++; $display("FAIL snap_complete: got ok=%0b count=%0d want 1/16", ok, log_addr.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < log_addr.size()) begin
                n_checks++;
                if (log_addr[k] !== 13'h050 + 13'(k) || log_data[k] !== 32'hB000_0000 + 32'(k) * 32'h11) begin
                    n_errors++;
                    $display("FAIL snap_word[%0d]: got %h/%h want %h/%h", k, log_addr[k], log_data[k], 13'h050 + 13'(k), 32'hB000_0000 + 32'(k) * 32'h11);
                end
            end
        end
        finish_row();
    endtask

    task automatic test_trig_drop();
        int cyc; bit ok; int guard; int done_seen;
        clear_log();
        row = 9'd7; data = make_row(32'hC000_0000, 32'h1); trig = 1'b1;
        guard = 0;
        while (log_addr.size() < 8 && guard < 100) begin @(negedge clk); guard++; end
        n_checks++; if (guard >= 100) begin n_errors++; $display("FAIL drop_reach_w7: got timeout count=%0d want 8", log_addr.size()); end
        trig = 1'b0;
        done_seen = 0;
        repeat (60) begin @(negedge clk); if (done !== 1'b0) done_seen++; end
        n_checks++; if (log_addr.size() != 16) begin n_errors++; $display("FAIL drop_count: got %0d want 16", log_addr.size()); end
        n_checks++; if (done_seen != 0) begin n_errors++; $display("FAIL drop_done: got %0d high samples want 0", done_seen); end
        n_checks++; if (log_addr.size() == 16 && (log_addr[15] !== 13'h07F || log_data[15] !== 32'hC000_000F)) begin
            n_errors++; $display("FAIL drop_last: got %h/%h want 07f/c000000f", log_addr[15], log_data[15]);
        end
        @(posedge clk); #1;
        clear_log();
        run_row(9'd8, make_row(32'h8000_0000, 32'h1), 1'b0, 200, cyc, ok);
        n_checks++; if (!ok || cyc != 67) begin n_errors++; $display("FAIL drop_restart: got ok=%0b cyc=%0d want cyc=67", ok, cyc); end
        finish_row();
    endtask

    task automatic test_stale_ack();
        int cyc; bit ok;
        clear_log();
        extra_hold = 3;
        run_row(9'd3, make_row(32'h3000_0000, 32'h2), 1'b0, 300, cyc, ok);
        n_checks++; if (!ok || cyc != 115) begin n_errors++; $display("FAIL hold3_latency: got ok=%0b cyc=%0d want 115", ok, cyc); end
        n_checks++; if (log_addr.size() != 16) begin n_errors++; $display("FAIL hold3_rises: got %0d want 16", log_addr.size()); end
        n_checks++; if (log_addr.size() == 16 && log_addr[15] !== 13'h03F) begin n_errors++; $display("FAIL hold3_last_addr: got %h want 03f", log_addr[15]); end
        n_checks++; if (stab_err != 0) begin n_errors++; $display("FAIL hold3_stable: got %0d changes want 0", stab_err); end
        extra_hold = 0;
        finish_row();
    endtask

    task automatic test_async_reset();
        int cyc; bit ok; int guard;
        clear_log();
        row = 9'd6; data = make_row(32'hE000_0000, 32'h1); trig = 1'b1;
        guard = 0;
        while (log_addr.size() < 10 && guard < 100) begin @(negedge clk); guard++; end
        n_checks++; if (guard >= 100) begin n_errors++; $display("FAIL arst_reach_w9: got timeout count=%0d want 10", log_addr.size()); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (btrig !== 1'b0)  begin n_errors++; $display("FAIL arst_trig: got %b want 0", btrig); end
        n_checks++; if (addr !== 13'h0)  begin n_errors++; $display("FAIL arst_addr: got %h want 0", addr); end
        n_checks++; if (wdata !== 32'h0) begin n_errors++; $display("FAIL arst_data: got %h want 0", wdata); end
        n_checks++; if (done !== 1'b0)   begin n_errors++; $display("FAIL arst_done: got %b want 0", done); end
        trig = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        clear_log();
        run_row(9'd2, make_row(32'hD000_0000, 32'h1), 1'b0, 200, cyc, ok);
        n_checks++; if (!ok || cyc != 67) begin n_errors++; $display("FAIL arst_restart: got ok=%0b cyc=%0d want 67", ok, cyc); end
        n_checks++; if (log_addr.size() != 16 || log_addr[0] !== 13'h020 || log_data[0] !== 32'hD000_0000) begin
            n_errors++; $display("FAIL arst_first_word: got count=%0d %h/%h want 16 020/d0000000", log_addr.size(), log_addr[0], log_data[0]);
        end
        finish_row();
    endtask

`ifdef WR512_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; bit ok; int guard; int hi;
        clear_log();
        silent_word = 3;
        row = 9'd1; data = make_row(32'h1000_0000, 32'h1); trig = 1'b1;
        guard = 0;
        while (log_addr.size() < 4 && guard < 100) begin @(negedge clk); guard++; end
        hi = 0;
        while (btrig && hi < 100) begin hi++; @(negedge clk); end
        n_checks++; if (hi != 20) begin n_errors++; $display("FAIL tmo_trig_width: got %0d want 20", hi); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b1 || done !== 1'b1) begin n_errors++; $display("FAIL tmo_flags: got err=%b done=%b want 1/1", err, done); end
        n_checks++; if (log_addr.size() != 4) begin n_errors++; $display("FAIL tmo_count: got %0d want 4", log_addr.size()); end
        finish_row();
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL tmo_sticky: got %b want 1", err); end
        silent_word = -1;
        run_row(9'd1, make_row(32'h1100_0000, 32'h1), 1'b0, 200, cyc, ok);
        n_checks++; if (!ok || err !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got ok=%0b err=%b want 1/0", ok, err); end
        finish_row();
    endtask
`endif

    initial begin
        bdone = 1'b0;
        test_reset();
        test_basic_row();
        test_snapshot();
        test_trig_drop();
        test_stale_ack();
        test_async_reset();
`ifdef WR512_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
